// File: rtl/xcore_bjp_pkg.sv
// Shared definitions for the xcore branch/jump resolve unit: branch-type
// encoding, ALU compare-result bit positions and resolve FSM states.
package xcore_bjp_pkg;

   localparam logic [2:0] BR_JMP    = 3'd0;
   localparam logic [2:0] BR_BEQ    = 3'd1;
   localparam logic [2:0] BR_BNE    = 3'd2;
   localparam logic [2:0] BR_BLT    = 3'd3;
   localparam logic [2:0] BR_BGT    = 3'd4;
   localparam logic [2:0] BR_BLTE   = 3'd5;
   localparam logic [2:0] BR_BGTE   = 3'd6;
   localparam logic [2:0] BR_FENCEI = 3'd7;

   localparam int CMP_EQ = 0;
   localparam int CMP_LT = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } bjp_state_e;

endpackage

// File: rtl/xcore_bjp_dir.sv
// Combinational direction resolve: decides whether the branch is taken,
// compares that with the fetch prediction and picks the redirect target.
module xcore_bjp_dir
   import xcore_bjp_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int SKIP_W = 2
) (
   input  logic [2:0]        br_type,
   input  logic [1:0]        cmp,
   input  logic [SKIP_W-1:0] skip,
   input  logic [XLEN-1:0]   pc,
   input  logic [XLEN-1:0]   alu_res,
   output logic              jump,
   output logic              flush,
   output logic              flush_type,
   output logic [XLEN-1:0]   target
);

   logic            eq;
   logic            lt;
   logic            pred;
   logic            taken;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pc_plus_skip;

   assign eq           = cmp[CMP_EQ];
   assign lt           = cmp[CMP_LT];
   assign pred         = |skip;
   assign pc_plus4     = pc + XLEN'(4);
   assign pc_plus_skip = pc + (XLEN'(skip) << 2);

   // Evaluate the branch condition for the encoded type
   always_comb begin
      taken = 1'b1;
      case (br_type)
         BR_JMP:  taken = 1'b1;
         BR_BEQ:  taken = eq;
         BR_BNE:  taken = ~eq;
         BR_BLT:  taken = lt;
         BR_BGT:  taken = ~lt & ~eq;
         BR_BLTE: taken = lt | eq;
         BR_BGTE: taken = ~lt;
         default: taken = 1'b1;
      endcase
   end

   // Compare actual direction with prediction and choose the redirect
   always_comb begin
      jump       = 1'b0;
      flush      = 1'b0;
      flush_type = 1'b0;
      target     = taken ? alu_res : pc_plus4;
      if (br_type == BR_FENCEI) begin
         jump   = 1'b1;
         flush  = 1'b1;
         target = pc_plus4;
      end else if (taken && !pred) begin
         jump       = 1'b1;
         flush      = 1'b1;
         flush_type = 1'b1;
         target     = alu_res;
      end else if (!taken && pred) begin
         jump   = 1'b1;
         flush  = 1'b1;
         target = pc_plus_skip;
      end
   end

endmodule

// File: rtl/xcore_bjp_resolve.sv
// Registered branch/jump resolve unit. Captures one resolve record per
// accepted branch, holds it for the PC generator over valid/ready and keeps
// a 1-bit flush epoch so wrong-path requests are dropped.
// Optional performance counters are built when XCORE_BJP_PERF_CNT_EN is defined.
module xcore_bjp_resolve
   import xcore_bjp_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ID_W   = 3,
   parameter int SKIP_W = 2
`ifdef XCORE_BJP_PERF_CNT_EN
   ,
   parameter int CNT_W  = 32
`endif
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_ex_valid,
   input  logic              i_ex_bjp_req,
   input  logic [2:0]        i_ex_br_type,
   input  logic [1:0]        i_ex_alu_cmp_res,
   input  logic [XLEN-1:0]   i_ex_alu_res,
   input  logic [XLEN-1:0]   i_ex_instr_pc,
   input  logic [SKIP_W-1:0] i_ex_instr_skip,
   input  logic [ID_W-1:0]   i_ex_instr_id,
   input  logic              i_ex_epoch,
   output logic              o_ex_ready,
   output logic              o_bjp_valid,
   input  logic              i_bjp_ready,
   output logic              o_bjp_jump_req,
   output logic              o_bjp_flush_req,
   output logic              o_bjp_flush_type,
   output logic [ID_W-1:0]   o_bjp_flush_id,
   output logic [XLEN-1:0]   o_bjp_target,
   output logic [XLEN-1:0]   o_bjp_res,
   output logic              o_epoch
`ifdef XCORE_BJP_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  o_perf_resolved,
   output logic [CNT_W-1:0]  o_perf_mispred
`endif
);

   bjp_state_e      state_q;
   bjp_state_e      state_d;
   logic            epoch_q;
   logic            accept;
   logic            dir_jump;
   logic            dir_flush;
   logic            dir_type;
   logic [XLEN-1:0] dir_target;

   xcore_bjp_dir #(
      .XLEN   (XLEN),
      .SKIP_W (SKIP_W)
   ) u_dir (
      .br_type    (i_ex_br_type),
      .cmp        (i_ex_alu_cmp_res),
      .skip       (i_ex_instr_skip),
      .pc         (i_ex_instr_pc),
      .alu_res    (i_ex_alu_res),
      .jump       (dir_jump),
      .flush      (dir_flush),
      .flush_type (dir_type),
      .target     (dir_target)
   );

   assign o_ex_ready  = (state_q == ST_IDLE) | i_bjp_ready;
   assign accept      = i_ex_valid & i_ex_bjp_req & o_ex_ready & (i_ex_epoch == epoch_q);
   assign o_bjp_valid = (state_q == ST_HOLD);
   assign o_epoch     = epoch_q;

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next state: a capture always lands in HOLD; HOLD drains only on ack without a new capture
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_HOLD;
         ST_HOLD: if (i_bjp_ready && !accept) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Resolve record register, reloaded on every accepted request
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_bjp_jump_req   <= 1'b0;
         o_bjp_flush_req  <= 1'b0;
         o_bjp_flush_type <= 1'b0;
         o_bjp_flush_id   <= '0;
         o_bjp_target     <= '0;
         o_bjp_res        <= '0;
      end else if (accept) begin
         o_bjp_jump_req   <= dir_jump;
         o_bjp_flush_req  <= dir_flush;
         o_bjp_flush_type <= dir_type;
         o_bjp_flush_id   <= i_ex_instr_id;
         o_bjp_target     <= dir_target;
         o_bjp_res        <= i_ex_instr_pc + XLEN'(4);
      end
   end

   // Epoch flips when a flushing record is captured, retiring the wrong path
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)                  epoch_q <= 1'b0;
      else if (accept && dir_flush)  epoch_q <= ~epoch_q;
   end

`ifdef XCORE_BJP_PERF_CNT_EN
   // Count resolved records and mispredictions (fence.i is not a misprediction)
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_perf_resolved <= '0;
         o_perf_mispred  <= '0;
      end else if (accept) begin
         o_perf_resolved <= o_perf_resolved + CNT_W'(1);
         if (dir_flush && (i_ex_br_type != BR_FENCEI))
            o_perf_mispred <= o_perf_mispred + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_xcore_bjp_resolve.sv
// Self-checking bench for xcore_bjp_resolve: directed scenarios plus
// randomized traffic compared against a transaction-level reference model.
module tb_xcore_bjp_resolve;

   localparam int XLEN   = 32;
   localparam int ID_W   = 3;
   localparam int SKIP_W = 2;

   logic              clk;
   logic              rst_n;
   logic              ex_valid;
   logic              ex_bjp_req;
   logic [2:0]        ex_br_type;
   logic [1:0]        ex_cmp;
   logic [XLEN-1:0]   ex_alu_res;
   logic [XLEN-1:0]   ex_pc;
   logic [SKIP_W-1:0] ex_skip;
   logic [ID_W-1:0]   ex_id;
   logic              ex_epoch;
   logic              ex_ready;
   logic              bjp_valid;
   logic              bjp_ready;
   logic              bjp_jump;
   logic              bjp_flush;
   logic              bjp_type;
   logic [ID_W-1:0]   bjp_id;
   logic [XLEN-1:0]   bjp_target;
   logic [XLEN-1:0]   bjp_res;
   logic              epoch;
`ifdef XCORE_BJP_PERF_CNT_EN
   logic [31:0]       perf_resolved;
   logic [31:0]       perf_mispred;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic              m_valid;
   logic              m_jump;
   logic              m_flush;
   logic              m_type;
   logic [ID_W-1:0]   m_id;
   logic [XLEN-1:0]   m_target;
   logic [XLEN-1:0]   m_res;
   logic              m_epoch;
   logic [31:0]       m_resolved;
   logic [31:0]       m_mispred;

   xcore_bjp_resolve dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_ex_valid       (ex_valid),
      .i_ex_bjp_req     (ex_bjp_req),
      .i_ex_br_type     (ex_br_type),
      .i_ex_alu_cmp_res (ex_cmp),
      .i_ex_alu_res     (ex_alu_res),
      .i_ex_instr_pc    (ex_pc),
      .i_ex_instr_skip  (ex_skip),
      .i_ex_instr_id    (ex_id),
      .i_ex_epoch       (ex_epoch),
      .o_ex_ready       (ex_ready),
      .o_bjp_valid      (bjp_valid),
      .i_bjp_ready      (bjp_ready),
      .o_bjp_jump_req   (bjp_jump),
      .o_bjp_flush_req  (bjp_flush),
      .o_bjp_flush_type (bjp_type),
      .o_bjp_flush_id   (bjp_id),
      .o_bjp_target     (bjp_target),
      .o_bjp_res        (bjp_res),
      .o_epoch          (epoch)
`ifdef XCORE_BJP_PERF_CNT_EN
      ,
      .o_perf_resolved  (perf_resolved),
      .o_perf_mispred   (perf_mispred)
`endif
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outcome from the branch rules: compare result viewed as a signed relation
   function automatic void predict(input logic [2:0] t, input logic [1:0] cmp,
                                   input logic [1:0] skip, input logic [31:0] pc,
                                   input logic [31:0] alu, output logic j,
                                   output logic f, output logic ty,
                                   output logic [31:0] tgt);
      int rel;
      bit taken;
      bit pred;
      rel  = cmp[1] ? -1 : (cmp[0] ? 0 : 1);
      pred = (skip != 0);
      case (t)
         3'd1:    taken = (rel == 0);
         3'd2:    taken = (rel != 0);
         3'd3:    taken = (rel < 0);
         3'd4:    taken = (rel > 0);
         3'd5:    taken = (rel <= 0);
         3'd6:    taken = (rel >= 0);
         default: taken = 1'b1;
      endcase
      if (t == 3'd7) begin
         j = 1'b1; f = 1'b1; ty = 1'b0; tgt = pc + 32'd4;
      end else if (taken == pred) begin
         j = 1'b0; f = 1'b0; ty = 1'b0; tgt = 32'd0;
      end else if (taken) begin
         j = 1'b1; f = 1'b1; ty = 1'b1; tgt = alu;
      end else begin
         j = 1'b1; f = 1'b1; ty = 1'b0; tgt = pc + 32'(skip) * 32'd4;
      end
   endfunction

   // Set EX and PC-gen inputs between clock edges
   task automatic drive(input logic v, input logic req, input logic [2:0] t,
                        input logic [1:0] cmp, input logic [1:0] skip,
                        input logic [31:0] pc, input logic [31:0] alu,
                        input logic [2:0] id, input logic ep, input logic rdy);
      @(negedge clk);
      ex_valid   = v;
      ex_bjp_req = req;
      ex_br_type = t;
      ex_cmp     = cmp;
      ex_skip    = skip;
      ex_pc      = pc;
      ex_alu_res = alu;
      ex_id      = id;
      ex_epoch   = ep;
      bjp_ready  = rdy;
   endtask

   // Advance one clock and update the reference model with the inputs seen at that edge
   task automatic step();
      logic rdy;
      logic acc;
      logic j, f, ty;
      logic [31:0] tgt;
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 0; m_jump = 0; m_flush = 0; m_type = 0; m_id = '0;
         m_target = '0; m_res = '0; m_epoch = 0; m_resolved = '0; m_mispred = '0;
      end else begin
         rdy = !m_valid || bjp_ready;
         acc = ex_valid && ex_bjp_req && rdy && (ex_epoch == m_epoch);
         if (acc) begin
            predict(ex_br_type, ex_cmp, ex_skip, ex_pc, ex_alu_res, j, f, ty, tgt);
            m_valid  = 1'b1;
            m_jump   = j;
            m_flush  = f;
            m_type   = ty;
            m_target = tgt;
            m_id     = ex_id;
            m_res    = ex_pc + 32'd4;
            if (f) m_epoch = ~m_epoch;
            m_resolved = m_resolved + 1;
            if (f && ex_br_type != 3'd7) m_mispred = m_mispred + 1;
         end else if (m_valid && bjp_ready) begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   // Reset state: every registered output and the epoch are zero
   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      step();
      checks++;
      if ({bjp_valid, bjp_jump, bjp_flush, bjp_type, bjp_id, bjp_target, bjp_res, epoch} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got v=%b j=%b f=%b t=%b id=%h tgt=%h res=%h ep=%b required all zero",
                  bjp_valid, bjp_jump, bjp_flush, bjp_type, bjp_id, bjp_target, bjp_res, epoch);
      end
`ifdef XCORE_BJP_PERF_CNT_EN
      checks++;
      if ({perf_resolved, perf_mispred} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_perf: got %0d/%0d required 0/0", perf_resolved, perf_mispred);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Directed outcome-table cases from a clean reset
   task automatic test_outcomes();
      drive(1, 1, 3'd1, 2'b01, 2'b00, 32'h100, 32'h200, 3'd1, 1'b0, 1'b1);
      step();
      checks++;
      if ({bjp_valid, bjp_jump, bjp_flush, bjp_type, bjp_target, bjp_res, bjp_id, epoch} !==
          {4'b1111, 32'h200, 32'h104, 3'd1, 1'b1}) begin
         failures++;
         $display("[TB] FAIL beq_taken_miss: got v%b j%b f%b t%b tgt=%h res=%h id=%h ep=%b required 1111 tgt=200 res=104 id=1 ep=1",
                  bjp_valid, bjp_jump, bjp_flush, bjp_type, bjp_target, bjp_res, bjp_id, epoch);
      end
      drive(1, 1, 3'd2, 2'b01, 2'b01, 32'h100, 32'h300, 3'd2, 1'b1, 1'b1);
      step();
      checks++;
      if ({bjp_valid, bjp_jump, bjp_flush, bjp_type, bjp_target, epoch} !== {4'b1110, 32'h104, 1'b0}) begin
         failures++;
         $display("[TB] FAIL bne_nottaken_miss: got v%b j%b f%b t%b tgt=%h ep=%b required 1110 tgt=104 ep=0",
                  bjp_valid, bjp_jump, bjp_flush, bjp_type, bjp_target, epoch);
      end
      drive(1, 1, 3'd3, 2'b10, 2'b11, 32'h180, 32'h400, 3'd3, 1'b0, 1'b1);
      step();
      checks++;
      if ({bjp_valid, bjp_jump, bjp_flush, bjp_id, bjp_res, epoch} !== {3'b100, 3'd3, 32'h184, 1'b0}) begin
         failures++;
         $display("[TB] FAIL blt_correct: got v%b j%b f%b id=%h res=%h ep=%b required v1 j0 f0 id=3 res=184 ep=0",
                  bjp_valid, bjp_jump, bjp_flush, bjp_id, bjp_res, epoch);
      end
      drive(1, 1, 3'd7, 2'b00, 2'b01, 32'hFFFF_FFFC, 32'h0, 3'd4, 1'b0, 1'b1);
      step();
      checks++;
      if ({bjp_valid, bjp_jump, bjp_flush, bjp_type, bjp_target, bjp_res} !== {4'b1110, 32'h0, 32'h0}) begin
         failures++;
         $display("[TB] FAIL fencei_wrap: got v%b j%b f%b t%b tgt=%h res=%h required 1110 tgt=0 res=0",
                  bjp_valid, bjp_jump, bjp_flush, bjp_type, bjp_target, bjp_res);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, epoch, 1'b1);
      step();
      checks++;
      if (bjp_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL drain_to_idle: got valid=%b required 0", bjp_valid);
      end
   endtask

   // Back-pressure: record held stable while stalled, then replaced without a bubble
   task automatic test_back_to_back();
      drive(1, 1, 3'd1, 2'b01, 2'b00, 32'h500, 32'h600, 3'd4, epoch, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 3'd0, 2'b00, 2'b00, 32'h700, 32'h800, 3'd5, epoch, 1'b0);
         #1;
         checks++;
         if (ex_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_ready: got %b required 0", ex_ready);
         end
         step();
         checks++;
         if ({bjp_valid, bjp_target, bjp_id, bjp_res} !== {1'b1, 32'h600, 3'd4, 32'h504}) begin
            failures++;
            $display("[TB] FAIL stall_stable: got v%b tgt=%h id=%h res=%h required v1 tgt=600 id=4 res=504",
                     bjp_valid, bjp_target, bjp_id, bjp_res);
         end
      end
      drive(1, 1, 3'd0, 2'b00, 2'b00, 32'h700, 32'h800, 3'd5, epoch, 1'b1);
      #1;
      checks++;
      if (ex_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ack_ready: got %b required 1", ex_ready);
      end
      step();
      checks++;
      if ({bjp_valid, bjp_jump, bjp_type, bjp_target, bjp_id, epoch} !== {3'b111, 32'h800, 3'd5, m_epoch}) begin
         failures++;
         $display("[TB] FAIL back_to_back: got v%b j%b t%b tgt=%h id=%h ep=%b required 111 tgt=800 id=5 ep=%b",
                  bjp_valid, bjp_jump, bjp_type, bjp_target, bjp_id, epoch, m_epoch);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, epoch, 1'b1);
      step();
   endtask

   // Wrong-path request with the old epoch is dropped after a flush capture
   task automatic test_stale_epoch();
      logic [31:0] snap;
      logic        old_ep;
      old_ep = m_epoch;
      drive(1, 1, 3'd1, 2'b01, 2'b00, 32'h900, 32'hA00, 3'd6, old_ep, 1'b1);
      step();
      snap = m_resolved;
      drive(1, 1, 3'd1, 2'b01, 2'b00, 32'h900, 32'hB00, 3'd7, old_ep, 1'b1);
      step();
      checks++;
      if ({bjp_valid, epoch} !== {1'b0, ~old_ep}) begin
         failures++;
         $display("[TB] FAIL stale_drop: got v%b ep=%b required v0 ep=%b", bjp_valid, epoch, ~old_ep);
      end
`ifdef XCORE_BJP_PERF_CNT_EN
      checks++;
      if (perf_resolved !== snap) begin
         failures++;
         $display("[TB] FAIL stale_perf: got %0d required %0d", perf_resolved, snap);
      end
`endif
      drive(0, 0, 0, 0, 0, 0, 0, 0, epoch, 1'b1);
      step();
   endtask

   // Reset while holding a record discards it and clears the epoch
   task automatic test_reset_in_hold();
      drive(1, 1, 3'd3, 2'b10, 2'b01, 32'hC00, 32'hD00, 3'd2, m_epoch, 1'b0);
      step();
      drive(1, 1, 3'd1, 2'b01, 2'b00, 32'hC00, 32'hD00, 3'd2, epoch, 1'b0);
      if (m_epoch == 1'b0) begin
         ex_epoch = 1'b0;
         bjp_ready = 1'b1;
         step();
         drive(1, 1, 3'd3, 2'b10, 2'b01, 32'hC00, 32'hD00, 3'd2, 1'b1, 1'b0);
      end
      rst_n = 1'b0;
      step();
      checks++;
      if ({bjp_valid, bjp_jump, bjp_flush, epoch} !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_in_hold: got v%b j%b f%b ep=%b required 0000", bjp_valid, bjp_jump, bjp_flush, epoch);
      end
`ifdef XCORE_BJP_PERF_CNT_EN
      checks++;
      if ({perf_resolved, perf_mispred} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_in_hold_perf: got %0d/%0d required 0/0", perf_resolved, perf_mispred);
      end
`endif
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
      rst_n = 1'b1;
      step();
   endtask

   // Random traffic against the reference model
   task automatic test_random();
      logic [1:0] cmp;
      logic       ep;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 2))
            0:       cmp = 2'b00;
            1:       cmp = 2'b01;
            default: cmp = 2'b10;
         endcase
         ep = ($urandom_range(0, 4) == 0) ? ~m_epoch : m_epoch;
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 9, 3'($urandom_range(0, 7)),
               cmp, 2'($urandom_range(0, 3)), {$urandom, 2'b00} , $urandom,
               3'($urandom_range(0, 7)), ep, $urandom_range(0, 9) < 7);
         #1;
         checks++;
         if (ex_ready !== (!m_valid || bjp_ready)) begin
            failures++;
            $display("[TB] FAIL rnd_ready: cycle %0d got %b required %b", n, ex_ready, !m_valid || bjp_ready);
         end
         step();
         checks++;
         if ({bjp_valid, epoch} !== {m_valid, m_epoch}) begin
            failures++;
            $display("[TB] FAIL rnd_valid_epoch: cycle %0d got v%b ep%b required v%b ep%b",
                     n, bjp_valid, epoch, m_valid, m_epoch);
         end
         if (m_valid) begin
            checks++;
            if ({bjp_jump, bjp_flush, bjp_type, bjp_id, bjp_res} !== {m_jump, m_flush, m_type, m_id, m_res}) begin
               failures++;
               $display("[TB] FAIL rnd_record: cycle %0d got j%b f%b t%b id=%h res=%h required j%b f%b t%b id=%h res=%h",
                        n, bjp_jump, bjp_flush, bjp_type, bjp_id, bjp_res, m_jump, m_flush, m_type, m_id, m_res);
            end
            if (m_jump) begin
               checks++;
               if (bjp_target !== m_target) begin
                  failures++;
                  $display("[TB] FAIL rnd_target: cycle %0d got %h required %h", n, bjp_target, m_target);
               end
            end
         end
`ifdef XCORE_BJP_PERF_CNT_EN
         checks++;
         if ({perf_resolved, perf_mispred} !== {m_resolved, m_mispred}) begin
            failures++;
            $display("[TB] FAIL rnd_perf: cycle %0d got %0d/%0d required %0d/%0d",
                     n, perf_resolved, perf_mispred, m_resolved, m_mispred);
         end
`endif
      end
   endtask

   // Test sequence
   initial begin
      rst_n = 1'b0;
      ex_valid = 0; ex_bjp_req = 0; ex_br_type = 0; ex_cmp = 0; ex_skip = 0;
      ex_pc = 0; ex_alu_res = 0; ex_id = 0; ex_epoch = 0; bjp_ready = 1;
      m_valid = 0; m_jump = 0; m_flush = 0; m_type = 0; m_id = '0;
      m_target = '0; m_res = '0; m_epoch = 0; m_resolved = '0; m_mispred = '0;
      test_reset();
      test_outcomes();
      test_back_to_back();
      test_stale_epoch();
      test_reset_in_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
